adex_param_sequencer: RTL
=========================

# adex_param_sequencer

Autonomous configuration controller for the AdEx neuron core. It holds an 8-byte parameter bank that the host writes. On a start command it replays the bank into the neuron's nibble-serial loader protocol (header strobe, 16 nibble strobes, footer strobe) and gates the neuron's core enable so that the core never integrates while it is being reconfigured. It sits between the host/pin interface and the neuron's `load_mode`/`load_enable`/nibble/`enable_core` inputs.

## Interface
Parameters:
- `STROBE_LO`, 2: cycles `load_enable` is held low before each rising edge; must be ≥2.
- `STROBE_HI`, 1: cycles `load_enable` is held high per strobe; must be ≥1.
- `FOOTER_NIB`, 4'hF: nibble sent on the footer strobe.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `wr_en` input 1: bank write strobe.
- `wr_addr` input 3: bank index; 0..7 = DeltaT, TauW, a, b, Vreset, VT, Ibias, C.
- `wr_data` input 8: bank write data.
- `start` input 1: single-cycle request to load the bank into the neuron.
- `abort` input 1: cancel any load; return to IDLE.
- `run_req` input 1: host request to run the neuron core.
- `load_mode` output 1: drives neuron `load_mode`.
- `load_enable` output 1: drives neuron `load_enable`.
- `nibble` output 4: drives neuron nibble input.
- `enable_core` output 1: drives neuron `enable_core`.
- `busy` output 1: high while a load is in progress.
- `done` output 1: high while the neuron holds a completed, armed configuration.

## Operation
- States: IDLE, DROP, ARM, LO, HI, DONE. Edge counter `k` runs 0..17. Phase counter sized for max(`STROBE_LO`, `STROBE_HI`).
- Nibble selected by `k`:
  - k=0: 4'h0 (header).
  - k=1..16: bank[(k−1)>>1]. Odd k sends bits [7:4]; even k sends bits [3:0].
  - k=17: `FOOTER_NIB`.
- IDLE:
  - `start` → ARM.
- ARM (1 cycle):
  - `load_mode`=1, `load_enable`=0, k=0 → LO.
- LO (`STROBE_LO` cycles):
  - `load_enable`=0; `nibble` = sel(k) → HI.
- HI (`STROBE_HI` cycles):
  - `load_enable`=1; `nibble` held at sel(k).
  - If k=17 → DONE; otherwise k++ → LO.
- DONE:
  - `load_mode` stays 1 so the neuron keeps its ready flag; `load_enable`=0; `done`=1.
  - `start` → DROP.
- DROP (1 cycle):
  - `load_mode`=0, which clears the neuron's armed state → ARM.
- `abort` from any state → IDLE next cycle with `load_mode`=0. `abort` wins over a simultaneous `start`.
- `start` in ARM/LO/HI/DROP: ignored.
- Bank writes:
  - Accepted only in IDLE or DONE. Ignored while `busy`.
  - A write in DONE does not alter the neuron until the next `start`.
- `enable_core` = `run_req` & (state ∈ {IDLE, DONE}); registered.
- Bank reset values, index 0..7: 130, 100, 1, 5, 63, 78, 180, 10.

## Timing
- All outputs are registered.
- Reset values: `load_mode`=0, `load_enable`=0, `nibble`=0, `enable_core`=0, `busy`=0, `done`=0; state IDLE; k=0.
- `start` sampled in cycle t → ARM outputs visible in cycle t+1.
- Load length from IDLE: 1 + 18·(`STROBE_LO`+`STROBE_HI`) cycles, then DONE. With defaults this is 55 cycles; `done` is first high in cycle t+56.
- Load from DONE takes one extra cycle for DROP.
- `nibble` is stable from `STROBE_LO` cycles before each rising edge of `load_enable` through the end of that high phase.
- `STROBE_LO`≥2 guarantees the neuron's one-cycle byte-latch step never coincides with a strobe.
- Total load must be <4000 cycles to stay inside the neuron's loader watchdog. Elaboration-time check: 18·(LO+HI)+1 < 4000.
- `busy` = state ∈ {DROP, ARM, LO, HI}.
- `enable_core` drops in the cycle DROP/ARM is entered and rises the cycle after DONE is entered (if `run_req`).
- Asynchronous reset mid-load: all outputs go to their reset values immediately. The bank returns to its defaults.

## Structure
- `adex_pkg` holds:
  - the state enum;
  - parameter-index constants (`IDX_DELTAT`..`IDX_C`);
  - the default bank values;
  - `FOOTER_NIB`;
  - the watchdog limit 4000.
- Sub-module `adex_param_bank`: 8×8 register file with async-reset defaults, write port, and combinational read of bank[idx]. The sequencer instantiates it once.
- Strobe timing and the k counter remain in `adex_param_sequencer`.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 mid-LO.
  - Required: all outputs 0 immediately; after release, a `start` replays the defaults.
- Default load:
  - Stimulus: `start` with defaults.
  - Required: 18 rising edges of `load_enable`.
  - Required nibbles on edges 1..17: 8,2,6,4,0,1,0,5,3,F,4,E,B,4,0,A,F.
  - Required: `done`=1 at start+56.
  - A behavioral neuron loader model on the bench must report ready and hold params equal to the bank.
- Custom bank:
  - Stimulus: write VT=0x5A and C=0x20, then `start`.
  - Required: edges 11/12 carry 5/A; edges 15/16 carry 2/0.
- Abort:
  - Stimulus: `abort` at k=7.
  - Required: next cycle IDLE, `load_mode`=0, `busy`=0. A simultaneous `start`+`abort` does not start a load.
- Reload:
  - Stimulus: `start` in DONE.
  - Required: one DROP cycle with `load_mode`=0, then a full load; `done`=1 after 56 cycles.
  - Required: a bank write issued during the load leaves the bank unchanged.
- Core gating:
  - Stimulus: `run_req`=1 throughout.
  - Required: `enable_core`=1 in IDLE, 0 throughout DROP..HI, 1 again the cycle after DONE is entered.

Source files
------------

// File: rtl/adex_pkg.sv
// Shared definitions for the AdEx parameter sequencer: state encoding,
// bank geometry, parameter indices, reset defaults and loader limits.
package adex_pkg;

    localparam int unsigned BANK_DEPTH     = 8;
    localparam int unsigned BANK_AW        = 3;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned NIB_W          = 4;
    localparam int unsigned K_W            = 5;
    localparam int unsigned K_LAST         = 17;   // header + 16 nibbles + footer
    localparam int unsigned NUM_EDGES      = 18;
    localparam int unsigned WATCHDOG_LIMIT = 4000; // neuron loader watchdog, cycles

    localparam logic [NIB_W-1:0] FOOTER_NIB_DFLT = 4'hF;

    localparam logic [BANK_AW-1:0] IDX_DELTAT = 3'd0;
    localparam logic [BANK_AW-1:0] IDX_TAUW   = 3'd1;
    localparam logic [BANK_AW-1:0] IDX_A      = 3'd2;
    localparam logic [BANK_AW-1:0] IDX_B      = 3'd3;
    localparam logic [BANK_AW-1:0] IDX_VRESET = 3'd4;
    localparam logic [BANK_AW-1:0] IDX_VT     = 3'd5;
    localparam logic [BANK_AW-1:0] IDX_IBIAS  = 3'd6;
    localparam logic [BANK_AW-1:0] IDX_C      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DROP,
        ST_ARM,
        ST_LO,
        ST_HI,
        ST_DONE
    } seq_state_e;

    // Power-on value of each bank entry.
    function automatic logic [BYTE_W-1:0] bank_default(input logic [BANK_AW-1:0] idx);
        logic [BYTE_W-1:0] v;
        case (idx)
            IDX_DELTAT: v = 8'd130;
            IDX_TAUW:   v = 8'd100;
            IDX_A:      v = 8'd1;
            IDX_B:      v = 8'd5;
            IDX_VRESET: v = 8'd63;
            IDX_VT:     v = 8'd78;
            IDX_IBIAS:  v = 8'd180;
            default:    v = 8'd10;   // IDX_C
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adex_param_sequencer_if.sv
// Host/neuron signal bundle of the parameter sequencer.
// master: host side (drives writes/commands, observes neuron drive and status)
// slave : sequencer side
interface adex_param_sequencer_if;
    import adex_pkg::*;

    logic                 wr_en;
    logic [BANK_AW-1:0]   wr_addr;
    logic [BYTE_W-1:0]    wr_data;
    logic                 start;
    logic                 abort;
    logic                 run_req;
    logic                 load_mode;
    logic                 load_enable;
    logic [NIB_W-1:0]     nibble;
    logic                 enable_core;
    logic                 busy;
    logic                 done;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort, run_req,
        input  load_mode, load_enable, nibble, enable_core, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort, run_req,
        output load_mode, load_enable, nibble, enable_core, busy, done
    );

endinterface

// File: rtl/adex_param_bank.sv
// 8x8 parameter register file with reset defaults.
// Ports: clk, rst_n; wr_en/wr_addr/wr_data write port; rd_idx -> rd_data_c
// combinational read.
module adex_param_bank
    import adex_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [BANK_AW-1:0] wr_addr,
    input  logic [BYTE_W-1:0]  wr_data,
    input  logic [BANK_AW-1:0] rd_idx,
    output logic [BYTE_W-1:0]  rd_data_c
);

    logic [BYTE_W-1:0] mem_q [BANK_DEPTH];

    // Storage: defaults on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                mem_q[i] <= bank_default(BANK_AW'(i));
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_idx];

endmodule

// File: rtl/adex_param_sequencer.sv
// Replays the parameter bank into the AdEx neuron's nibble-serial loader
// (header, 16 nibbles, footer) and holds the core disabled while loading.
// Ports: clk, rst_n; bus (slave): host writes/start/abort/run_req in,
// load_mode/load_enable/nibble/enable_core/busy/done out (all registered).
module adex_param_sequencer
    import adex_pkg::*;
#(
    parameter int unsigned      STROBE_LO  = 2,
    parameter int unsigned      STROBE_HI  = 1,
    parameter logic [NIB_W-1:0] FOOTER_NIB = FOOTER_NIB_DFLT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adex_param_sequencer_if.slave bus
);

    localparam int unsigned PH_MAX      = (STROBE_LO > STROBE_HI) ? STROBE_LO : STROBE_HI;
    localparam int unsigned PH_W        = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned LOAD_CYCLES = NUM_EDGES * (STROBE_LO + STROBE_HI) + 1;

    // Parameter legality.
    if (STROBE_LO < 2) begin : g_chk_lo
        $error("STROBE_LO must be >= 2");
    end
    if (STROBE_HI < 1) begin : g_chk_hi
        $error("STROBE_HI must be >= 1");
    end
    if (LOAD_CYCLES >= WATCHDOG_LIMIT) begin : g_chk_wdog
        $error("load length exceeds neuron loader watchdog");
    end

    seq_state_e        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [PH_W-1:0]   ph_q, ph_d;

    logic              load_mode_q, load_mode_d;
    logic              load_enable_q, load_enable_d;
    logic [NIB_W-1:0]  nibble_q, nibble_d;
    logic              enable_core_q, enable_core_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BANK_AW-1:0] rd_idx_c;
    logic [BYTE_W-1:0]  bank_rd_c;
    logic [NIB_W-1:0]   nib_sel_c;
    logic               bank_wr_c;

    function automatic logic at_rest(input seq_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

    // Writes only land while no load is in flight.
    assign bank_wr_c = bus.wr_en && at_rest(state_q);
    // Edge k (1..16) reads byte (k-1)/2; k=0 index is don't-care.
    assign rd_idx_c  = BANK_AW'((k_d - K_W'(1)) >> 1);

    adex_param_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bank_wr_c),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .rd_idx    (rd_idx_c),
        .rd_data_c (bank_rd_c)
    );

    // Nibble for edge k: header, high/low byte halves, footer.
    always_comb begin
        nib_sel_c = bank_rd_c[3:0];
        if (k_d == '0) begin
            nib_sel_c = '0;
        end else if (k_d == K_W'(K_LAST)) begin
            nib_sel_c = FOOTER_NIB;
        end else if (k_d[0]) begin
            nib_sel_c = bank_rd_c[7:4];
        end
    end

    // Next state, edge counter and strobe phase counter.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ph_d    = ph_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                    k_d     = '0;
                    ph_d    = '0;
                end
            end
            ST_DROP: begin
                state_d = ST_ARM;
                k_d     = '0;
                ph_d    = '0;
            end
            ST_ARM: begin
                state_d = ST_LO;
                k_d     = '0;
                ph_d    = '0;
            end
            ST_LO: begin
                if (ph_q == PH_W'(STROBE_LO - 1)) begin
                    state_d = ST_HI;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HI: begin
                if (ph_q == PH_W'(STROBE_HI - 1)) begin
                    ph_d = '0;
                    if (k_q == K_W'(K_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LO;
                        k_d     = k_q + K_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
                ph_d    = '0;
            end
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
            k_d     = '0;
            ph_d    = '0;
        end
    end

    // Output decode from the state being entered, so registers line up with it.
    always_comb begin
        load_mode_d   = state_d inside {ST_ARM, ST_LO, ST_HI, ST_DONE};
        load_enable_d = (state_d == ST_HI);
        busy_d        = state_d inside {ST_DROP, ST_ARM, ST_LO, ST_HI};
        done_d        = (state_d == ST_DONE);
        nibble_d      = load_mode_d ? nib_sel_c : '0;
        // Falls on entry to DROP/ARM; rises one cycle after DONE is reached.
        enable_core_d = bus.run_req && at_rest(state_q) && at_rest(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            ph_q          <= '0;
            load_mode_q   <= 1'b0;
            load_enable_q <= 1'b0;
            nibble_q      <= '0;
            enable_core_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            ph_q          <= ph_d;
            load_mode_q   <= load_mode_d;
            load_enable_q <= load_enable_d;
            nibble_q      <= nibble_d;
            enable_core_q <= enable_core_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.load_mode   = load_mode_q;
    assign bus.load_enable = load_enable_q;
    assign bus.nibble      = nibble_q;
    assign bus.enable_core = enable_core_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
